syn_bank: RTL and testbench



---
 rtl/syn_bank.sv | 145 ++++++++++++++
 tb/tb_syn_bank.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/syn_bank.sv
// Purpose : bank of N_CH exponential-decay current synapses sharing one signed multiplier, one channel per cycle.
// Latency : tick at E0 -> channel k updated at E(k+1); done pulses and busy drops at E(N_CH).
// Backpres: none; a tick arriving mid-sweep is dropped and latches the sticky overrun flag.
//
// Ports: clk/rst_n (async active-low); tick starts a sweep; spike_in marks channels for weight add;
//        w_we/w_addr/w_data write a weight in any state; i_syn packs registered currents (ch k at
//        [k*WIDTH +: WIDTH]); busy/done/overrun report sweep status; sat_flag reports clamping.
// Optional: define SYN_SAT_FLAG_EN to build sticky per-channel saturation flags (else tied to 0).
module syn_bank #(
    parameter int N_CH = 8,
    parameter int WIDTH = 16,
    parameter logic [WIDTH-1:0] DECAY = 16'h7eb8,
    parameter logic [WIDTH-1:0] DEFAULT_WEIGHT = 16'h05ff,
    localparam int AW = $clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tick,
    input  logic [N_CH-1:0]         spike_in,
    input  logic                    w_we,
    input  logic [AW-1:0]           w_addr,
    input  logic [WIDTH-1:0]        w_data,
    output logic [N_CH*WIDTH-1:0]   i_syn,
    output logic                    busy,
    output logic                    done,
    output logic                    overrun,
    output logic [N_CH-1:0]         sat_flag
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SWEEP = 1'b1;
    localparam logic [AW-1:0] LAST = AW'(N_CH - 1);

    logic [0:0]       state;
    logic [AW-1:0]    idx;
    logic [N_CH-1:0]  pending;
    logic [N_CH-1:0]  active;
    logic [WIDTH-1:0] cur [N_CH];
    logic [WIDTH-1:0] w   [N_CH];

    // Shared datapath: decay the selected channel and optionally add its weight.
    logic [WIDTH-1:0]   cur_sel;
    logic [WIDTH-1:0]   w_sel;
    logic [WIDTH-1:0]   mag_a;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   prod_mag;
    logic [WIDTH-1:0]   decayed;
    logic [WIDTH:0]     sum;
    logic               clamp;
    logic [WIDTH-1:0]   sat_val;
    logic               unused_prod;

    always_comb begin
        cur_sel = cur[idx];
        w_sel   = w[idx];
        // Sign-magnitude multiply so the result truncates toward zero for negative currents.
        mag_a    = cur_sel[WIDTH-1] ? (~cur_sel + 1'b1) : cur_sel;
        prod     = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, DECAY};
        // DECAY < 1.0, so the shifted magnitude always fits below the sign bit.
        prod_mag = prod[2*WIDTH-2:WIDTH-1];
        decayed  = cur_sel[WIDTH-1] ? (~prod_mag + 1'b1) : prod_mag;
        sum      = {decayed[WIDTH-1], decayed}
                 + (active[idx] ? {w_sel[WIDTH-1], w_sel} : {(WIDTH+1){1'b0}});
        // Overflow exactly when the extra sign bit disagrees with the WIDTH-bit sign.
        clamp    = sum[WIDTH] ^ sum[WIDTH-1];
        if (!clamp)
            sat_val = sum[WIDTH-1:0];
        else if (sum[WIDTH])
            sat_val = {1'b1, {(WIDTH-1){1'b0}}};
        else
            sat_val = {1'b0, {(WIDTH-1){1'b1}}};
    end

    assign unused_prod = ^{prod[2*WIDTH-1], prod[WIDTH-2:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            pending <= '0;
            active  <= '0;
            done    <= 1'b0;
            overrun <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                cur[k] <= '0;
                w[k]   <= DEFAULT_WEIGHT;
            end
        end else begin
            done <= 1'b0;
            // Non-blocking write: an update of the same channel this cycle still sees the old weight.
            if (w_we)
                w[w_addr] <= w_data;
            case (state)
                IDLE: begin
                    if (tick) begin
                        // Spikes present on the accepting edge join this sweep.
                        active  <= pending | spike_in;
                        pending <= '0;
                        idx     <= '0;
                        state   <= SWEEP;
                    end else begin
                        pending <= pending | spike_in;
                    end
                end
                default: begin
                    pending  <= pending | spike_in;
                    if (tick)
                        overrun <= 1'b1;
                    cur[idx] <= sat_val;
                    if (idx == LAST) begin
                        idx   <= '0;
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
            endcase
        end
    end

    assign busy = (state == SWEEP);

    always_comb begin
        i_syn = '0;
        for (int k = 0; k < N_CH; k++)
            i_syn[k*WIDTH +: WIDTH] = cur[k];
    end

`ifdef SYN_SAT_FLAG_EN
    logic [N_CH-1:0] sat_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sat_q <= '0;
        else if (state == SWEEP && clamp)
            sat_q[idx] <= 1'b1;
    end
    assign sat_flag = sat_q;
`else
    logic unused_clamp;
    assign unused_clamp = clamp;
    assign sat_flag = '0;
`endif

endmodule

// File: tb/tb_syn_bank.sv
// Purpose : randomized self-checking bench for syn_bank against a sweep-level reference model.
// Latency : checks done/busy at E(N) of every sweep and all currents after each sweep.
// Backpres: drives overrun ticks and mid-sweep spikes/weight writes to exercise deferral rules.
module tb_syn_bank;
    localparam int N  = 4;
    localparam int W  = 16;
    localparam int AW = 2;
    localparam longint DEC = 32'h7eb8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           tick = 1'b0;
    logic [N-1:0]   spike_in = '0;
    logic           w_we = 1'b0;
    logic [AW-1:0]  w_addr = '0;
    logic [W-1:0]   w_data = '0;
    logic [N*W-1:0] i_syn;
    logic           busy;
    logic           done;
    logic           overrun;
    logic [N-1:0]   sat_flag;

    int total = 0;
    int bad = 0;

    // Reference model state
    int           mcur [N];
    int           mw   [N];
    logic [N-1:0] mpend;
    bit           movr;
    logic [N-1:0] msat;

    syn_bank #(.N_CH(N), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .spike_in(spike_in),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .i_syn(i_syn),
        .busy(busy), .done(done), .overrun(overrun), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            mcur[k] = 0;
            mw[k]   = 16'sh05ff;
        end
        mpend = '0;
        movr  = 1'b0;
        msat  = '0;
    endtask

    // Decay by DECAY/2^15 with magnitude truncation, then add weight.
    function automatic int next_cur(input int c, input int wt, input bit act);
        longint mag;
        longint d;
        mag = (c < 0) ? -c : c;
        d   = (mag * DEC) / 32768;
        return ((c < 0) ? -int'(d) : int'(d)) + (act ? wt : 0);
    endfunction

    function automatic logic [W-1:0] ch(input int k);
        return i_syn[k*W +: W];
    endfunction

    task automatic check_all(input string tag);
        logic [N-1:0] sexp;
`ifdef SYN_SAT_FLAG_EN
        sexp = msat;
`else
        sexp = '0;
`endif
        for (int k = 0; k < N; k++)
            check($sformatf("%s_ch%0d", tag, k), 32'(ch(k)), 32'(mcur[k][W-1:0]));
        check({tag, "_ovr"}, 32'(overrun), 32'(movr));
        check({tag, "_sat"}, 32'(sat_flag), 32'(sexp));
    endtask

    task automatic write_w(input logic [AW-1:0] a, input logic [W-1:0] d);
        w_we = 1'b1; w_addr = a; w_data = d;
        @(posedge clk); #1;
        w_we = 1'b0;
        mw[a] = int'($signed(d));
    endtask

    // One sweep: tick+sp at E0; optional late spike/tick at E(late_at) (1..N);
    // optional weight write sampled at E(wr_at) (0..N, -1 = none).
    task automatic run_sweep(input logic [N-1:0] sp, input int late_at, input logic [N-1:0] late_sp,
                             input bit late_tick, input int wr_at, input logic [AW-1:0] wa,
                             input logic [W-1:0] wd);
        logic [N-1:0] act;
        int s;
        int wt;
        act   = mpend | sp;
        mpend = (late_at >= 1 && late_at <= N) ? late_sp : '0;
        for (int k = 0; k < N; k++) begin
            // A write landing after channel k's update edge leaves k on the old weight.
            wt = (wr_at >= 0 && int'(wa) == k && wr_at <= k) ? int'($signed(wd)) : mw[k];
            s  = next_cur(mcur[k], wt, act[k]);
            if (s > 32767) begin s = 32767; msat[k] = 1'b1; end
            if (s < -32768) begin s = -32768; msat[k] = 1'b1; end
            mcur[k] = s;
        end
        if (wr_at >= 0) mw[wa] = int'($signed(wd));
        if (late_tick && late_at >= 1 && late_at < N) movr = 1'b1;

        for (int c = 0; c <= N; c++) begin
            tick     = (c == 0) || (late_tick && c == late_at && c < N);
            spike_in = (c == 0) ? sp : ((c == late_at) ? late_sp : '0);
            w_we     = (c == wr_at);
            w_addr   = wa;
            w_data   = wd;
            @(posedge clk); #1;
            if (c == 0) begin
                check("busy_start", 32'(busy), 32'd1);
                check("done_clr", 32'(done), 32'd0);
            end
        end
        check("done_end", 32'(done), 32'd1);
        check("busy_end", 32'(busy), 32'd0);
        tick = 1'b0; spike_in = '0; w_we = 1'b0;
    endtask

    initial begin
        model_reset();
        #23;
        check("rst_isyn", 32'(i_syn == '0), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        check("rst_sat", 32'(sat_flag), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_sweep('0, 0, '0, 0, -1, '0, '0);
        check_all("idle");

        run_sweep(4'b0100, 0, '0, 0, -1, '0, '0);
        check_all("sp2");
        check("ch2_05ff", 32'(ch(2)), 32'h05ff);
        run_sweep('0, 0, '0, 0, -1, '0, '0);
        check("ch2_05ef", 32'(ch(2)), 32'h05ef);

        write_w(2'd1, 16'h7000);
        run_sweep(4'b0010, 0, '0, 0, -1, '0, '0);
        check("ch1_7000", 32'(ch(1)), 32'h7000);
        run_sweep(4'b0010, 0, '0, 0, -1, '0, '0);
        check("ch1_7fff", 32'(ch(1)), 32'h7fff);
        check_all("sat_pos");

        write_w(2'd3, 16'hf000);
        run_sweep(4'b1000, 0, '0, 0, -1, '0, '0);
        check("ch3_f000", 32'(ch(3)), 32'hf000);
        run_sweep('0, 0, '0, 0, -1, '0, '0);
        check("ch3_f029", 32'(ch(3)), 32'hf029);
        write_w(2'd0, 16'h9000);
        run_sweep(4'b0001, 0, '0, 0, -1, '0, '0);
        run_sweep(4'b0001, 0, '0, 0, -1, '0, '0);
        check("ch0_8000", 32'(ch(0)), 32'h8000);
        check_all("sat_neg");

        run_sweep('0, 2, 4'b0001, 1, -1, '0, '0);
        check("ovr_set", 32'(overrun), 32'd1);
        check_all("ovr");

        // Reset in the middle of a sweep with a spike already pending.
        tick = 1'b1; spike_in = 4'b0011;
        @(posedge clk); #1;
        tick = 1'b0; spike_in = 4'b1000;
        @(posedge clk); #1;
        spike_in = '0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("mid_isyn", 32'(i_syn == '0), 32'd1);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_done", 32'(done), 32'd0);
        check("mid_ovr", 32'(overrun), 32'd0);
        check("mid_sat", 32'(sat_flag), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        run_sweep('0, 0, '0, 0, -1, '0, '0);
        check_all("post_rst");

        run_sweep('0, 2, 4'b0001, 1, -1, '0, '0);
        check("ovr_ch0_hold", 32'(ch(0)), 32'h0000);
        check("ovr_flag", 32'(overrun), 32'd1);
        run_sweep('0, 0, '0, 0, -1, '0, '0);
        check("ovr_ch0_next", 32'(ch(0)), 32'h05ff);
        check_all("ovr_next");

        // Same-edge weight write on channel 1's update: old weight used.
        run_sweep(4'b0010, 2, '0, 0, 2, 2'd1, 16'h0100);
        check_all("wr_same");

        for (int it = 0; it < 24; it++) begin
            int la;
            int wa_t;
            bit lt;
            if ($urandom_range(0, 1) == 1)
                write_w(AW'($urandom_range(0, N-1)), W'($urandom));
            la   = $urandom_range(0, N);
            lt   = (la >= 1 && la < N && $urandom_range(0, 3) == 0);
            wa_t = ($urandom_range(0, 2) == 0) ? $urandom_range(0, N) : -1;
            run_sweep(N'($urandom), la, N'($urandom), lt, wa_t,
                      AW'($urandom_range(0, N-1)), W'($urandom));
            check_all($sformatf("rnd%0d", it));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
